// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_ADDR_BITS = 2;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port, no reset on the array.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DATA_SIZE-1:0] rd_data_o
);

    localparam int DEPTH = fifo_depth(ADDR_BITS);

    logic [DATA_SIZE-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy count, threshold flags,
// sticky error flags and either registered or first-word-fall-through reads.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int AF_LEVEL  = 3,
    parameter int AE_LEVEL  = 1,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 we,
    input  logic [DATA_SIZE-1:0] wrdata,
    input  logic                 re,
    output logic [DATA_SIZE-1:0] rddata,
    output logic                 rdvalid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int            PW        = ADDR_BITS + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [PW-1:0]        wp_q, wp_d;
    logic [PW-1:0]        rp_q, rp_d;
    logic [PW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [DATA_SIZE-1:0] head_data;

    assign full         = (wp_q[ADDR_BITS] != rp_q[ADDR_BITS]) &&
                          (wp_q[ADDR_BITS-1:0] == rp_q[ADDR_BITS-1:0]);
    assign empty        = (wp_q == rp_q);
    assign almost_full  = (count_q >= AF_THRESH);
    assign almost_empty = (count_q <= AE_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A flush cycle swallows any request: nothing is accepted and nothing is flagged.
    assign wr_accept = we & ~full & ~clr;
    assign rd_accept = re & ~empty & ~clr;

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wp_d        = '0;
            rp_d        = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) wp_d = wp_q + 1'b1;
            if (rd_accept) rp_d = rp_q + 1'b1;
            if (wr_accept && !rd_accept) begin
                count_d = count_q + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count_d = count_q - 1'b1;
            end
            if (we && full)  overflow_d  = 1'b1;
            if (re && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wp_q[ADDR_BITS-1:0]),
        .wr_data_i (wrdata),
        .rd_addr_i (rp_q[ADDR_BITS-1:0]),
        .rd_data_o (head_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown only while valid so reset and flush present zero data.
            assign rddata  = empty ? '0 : head_data;
            assign rdvalid = ~empty;
        end else begin : g_reg_read
            logic [DATA_SIZE-1:0] rddata_q, rddata_d;
            logic                 rdvalid_q, rdvalid_d;

            always_comb begin
                rddata_d  = rddata_q;
                rdvalid_d = 1'b0;
                if (clr) begin
                    rddata_d = '0;
                end else if (rd_accept) begin
                    rddata_d  = head_data;
                    rdvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else begin
                    rddata_q  <= rddata_d;
                    rdvalid_q <= rdvalid_d;
                end
            end

            assign rddata  = rddata_q;
            assign rdvalid = rdvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read and a FWFT instance share stimulus
// and are checked against a queue-based model of the FIFO rules.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    localparam int DW = DEFAULT_DATA_SIZE;
    localparam int AB = DEFAULT_ADDR_BITS;
    localparam int D  = 4;
    localparam logic [17:0] RESET_VEC = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    logic clk = 1'b0;
    logic rst, clr, we, re;
    logic [DW-1:0] wrdata;
    logic [DW-1:0] rddata0, rddata1;
    logic rdvalid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic rdvalid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [AB:0] count0, count1;

    int errors = 0;
    int checks = 0;
    int txn = 0;

    logic [DW-1:0] q[$];
    logic          ovf_m, udf_m, rv_m;
    logic [DW-1:0] rd_m;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_SIZE(DW), .ADDR_BITS(AB), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .wrdata(wrdata), .re(re),
        .rddata(rddata0), .rdvalid(rdvalid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    param_sync_fifo #(.DATA_SIZE(DW), .ADDR_BITS(AB), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .wrdata(wrdata), .re(re),
        .rddata(rddata1), .rdvalid(rdvalid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rv_m  = 1'b0;
        rd_m  = '0;
    endtask

    // Applies one cycle of requests, advances the model, and returns 1 time unit after the edge.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic wok, rok;
        we = w; wrdata = d; re = r; clr = c;
        if (c) begin
            model_reset();
        end else begin
            wok  = w && (q.size() < D);
            rok  = r && (q.size() != 0);
            rv_m = rok;
            if (rok) rd_m = q.pop_front();
            if (wok) q.push_back(d);
            if (w && !wok) ovf_m = 1'b1;
            if (r && !rok) udf_m = 1'b1;
        end
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; clr = 1'b0;
        txn++;
        $display("txn %0d: we=%0b re=%0b clr=%0b wrdata=%02h | count=%0d rddata=%02h rdvalid=%0b fwft_rddata=%02h fwft_rdvalid=%0b ovf=%0b udf=%0b",
                 txn, w, r, c, d, count0, rddata0, rdvalid0, rddata1, rdvalid1, ovf0, udf0);
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; wrdata = '0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({count0, empty0, ae0, full0, af0, ovf0, udf0, rdvalid0, rddata0} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_u0: got %05h expected %05h",
                     {count0, empty0, ae0, full0, af0, ovf0, udf0, rdvalid0, rddata0}, RESET_VEC);
        end
        checks++;
        if ({count1, empty1, ae1, full1, af1, ovf1, udf1, rdvalid1, rddata1} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_u1: got %05h expected %05h",
                     {count1, empty1, ae1, full1, af1, ovf1, udf1, rdvalid1, rddata1}, RESET_VEC);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        checks++;
        if ({af0, full0} !== 2'b10) begin
            errors++; $display("FAIL fill_three: af,full=%02b expected 10", {af0, full0});
        end
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        checks++;
        if ({full0, af0, count0} !== {1'b1, 1'b1, 3'd4}) begin
            errors++; $display("FAIL fill_four: full=%0b af=%0b count=%0d expected 1 1 4", full0, af0, count0);
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        checks++;
        if ({ovf0, count0} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL fill_overflow: ovf=%0b count=%0d expected 1 4", ovf0, count0);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp_vals [4];
        exp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rdvalid1, rddata1} !== {1'b1, exp_vals[i]}) begin
                errors++; $display("FAIL drain_fwft_head%0d: rdvalid=%0b rddata=%02h expected 1 %02h", i, rdvalid1, rddata1, exp_vals[i]);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if ({rdvalid0, rddata0} !== {1'b1, exp_vals[i]}) begin
                errors++; $display("FAIL drain_word%0d: rdvalid=%0b rddata=%02h expected 1 %02h", i, rdvalid0, rddata0, exp_vals[i]);
            end
        end
        checks++;
        if (empty0 !== 1'b1) begin
            errors++; $display("FAIL drain_empty: empty=%0b expected 1", empty0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({udf0, rdvalid0} !== 2'b10) begin
            errors++; $display("FAIL drain_underflow: udf=%0b rdvalid=%0b expected 1 0", udf0, rdvalid0);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if ({count0, rddata1} !== {3'd1, 8'(i)}) begin
                errors++; $display("FAIL wrap_write%0d: count=%0d fwft_rddata=%02h expected 1 %02h", i, count0, rddata1, 8'(i));
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if ({count0, rdvalid0, rddata0} !== {3'd0, 1'b1, 8'(i)}) begin
                errors++; $display("FAIL wrap_read%0d: count=%0d rdvalid=%0b rddata=%02h expected 0 1 %02h", i, count0, rdvalid0, rddata0, 8'(i));
            end
        end
        checks++;
        if ({ovf0, udf0, ovf1, udf1} !== 4'b0000) begin
            errors++; $display("FAIL wrap_flags: ovf/udf u0,u1=%04b expected 0000", {ovf0, udf0, ovf1, udf1});
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_pop [3];
        exp_pop = '{8'hA0, 8'hA1, 8'hB0};
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'hB0 + 8'(k), 1'b1, 1'b0);
            checks++;
            if ({count0, rddata0} !== {3'd2, exp_pop[k]}) begin
                errors++; $display("FAIL simul_mid%0d: count=%0d rddata=%02h expected 2 %02h", k, count0, rddata0, exp_pop[k]);
            end
        end
        drive(1'b1, 8'hC0, 1'b0, 1'b0);
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        drive(1'b1, 8'hD0, 1'b1, 1'b0);
        checks++;
        if ({count0, ovf0, udf0} !== {3'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_full: count=%0d ovf=%0b udf=%0b expected 3 1 0", count0, ovf0, udf0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'hE0, 1'b1, 1'b0);
        checks++;
        if ({count0, udf0, ovf0} !== {3'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_empty: count=%0d udf=%0b ovf=%0b expected 1 1 0", count0, udf0, ovf0);
        end
    endtask

    task automatic test_fwft();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if ({rdvalid1, rddata1} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL fwft_show: rdvalid=%0b rddata=%02h expected 1 a5", rdvalid1, rddata1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({empty1, rdvalid1} !== 2'b10) begin
            errors++; $display("FAIL fwft_pop: empty=%0b rdvalid=%0b expected 1 0", empty1, rdvalid1);
        end
    endtask

    task automatic test_clr();
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({count0, ovf0} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL clr_setup: count=%0d ovf=%0b expected 3 1", count0, ovf0);
        end
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        checks++;
        if ({count0, empty0, ovf0, rdvalid0, rddata0} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL clr_flush: count=%0d empty=%0b ovf=%0b rdvalid=%0b rddata=%02h expected 0 1 0 0 00",
                               count0, empty0, ovf0, rdvalid0, rddata0);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b1, 1'b0);
        we = 1'b1; wrdata = 8'h63;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({count0, empty0, ae0, full0, af0, ovf0, udf0, rdvalid0, rddata0} !== RESET_VEC) begin
            errors++; $display("FAIL rst_mid_u0: got %05h expected %05h",
                               {count0, empty0, ae0, full0, af0, ovf0, udf0, rdvalid0, rddata0}, RESET_VEC);
        end
        checks++;
        if ({count1, empty1, rdvalid1, rddata1} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rst_mid_u1: count=%0d empty=%0b rdvalid=%0b rddata=%02h expected 0 1 0 00",
                               count1, empty1, rdvalid1, rddata1);
        end
        #2 rst = 1'b0;
        we = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({count0, empty0} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL rst_mid_after: count=%0d empty=%0b expected 0 1", count0, empty0);
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        logic [17:0] exp0, act0;
        for (int i = 0; i < 120; i++) begin
            w = (i % 40 < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i % 40 < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            drive(w, 8'($urandom), r, c);
            exp0 = {3'(q.size()), q.size() == D, q.size() == 0, q.size() >= 3, q.size() <= 1,
                    ovf_m, udf_m, rv_m, rd_m};
            act0 = {count0, full0, empty0, af0, ae0, ovf0, udf0, rdvalid0, rddata0};
            checks++;
            if (act0 !== exp0) begin
                errors++; $display("FAIL rand_u0 txn %0d: got %05h expected %05h", txn, act0, exp0);
            end
            checks++;
            if ({count1, rdvalid1, ovf1, udf1} !== {3'(q.size()), q.size() != 0, ovf_m, udf_m}) begin
                errors++; $display("FAIL rand_u1 txn %0d: count=%0d rdvalid=%0b ovf=%0b udf=%0b expected %0d %0b %0b %0b",
                                   txn, count1, rdvalid1, ovf1, udf1, q.size(), q.size() != 0, ovf_m, udf_m);
            end
            if (q.size() != 0) begin
                checks++;
                if (rddata1 !== q[0]) begin
                    errors++; $display("FAIL rand_u1_head txn %0d: rddata=%02h expected %02h", txn, rddata1, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_clr();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
